ts_os_gen: RTL
==============

Name: ts_os_gen

Overview:
- Byte-serial training-set transmitter: generates TS1/TS2 ordered sets (16 symbols each) as an 8-bit symbol stream with K-flag.
- Drives the same txdata/txdatak symbol interface that the lane-side TS receiver parses; sits between the LTSSM controller and the lane symbol path.
- Bursts are counted or continuous, with optional SKP ordered-set insertion.

Parameters:
- TS_LEN, 16, symbols per training set (fixed protocol value; not intended to change)
- SKP_INTERVAL, 4, completed sets between SKP ordered sets (used only with the SKP feature)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- en_n  in  1  synchronous disable, active high; aborts and clears like reset
- start  in  1  begin burst; sampled only in IDLE
- stop  in  1  end continuous or counted burst after the current set
- num_sets  in  8  sets per burst, latched on start; 0 = continuous until stop
- ts_type  in  1  0 = TS1 (ID 8'h4A), 1 = TS2 (ID 8'h45)
- pad_link  in  1  symbol 1 = PAD instead of link_num
- pad_lane  in  1  symbol 2 = PAD instead of lane_num
- link_num  in  8  symbol 1 value
- lane_num  in  8  symbol 2 value
- nfts  in  8  symbol 3 value
- rate_id  in  8  symbol 4 value
- train_ctrl  in  8  symbol 5 value
- txdata  out  8  symbol out, registered
- txdatak  out  1  K-symbol flag, registered
- busy  out  1  high while any set or SKP symbol is driven
- set_done  out  1  one-cycle pulse on symbol 15 of each TS
- tsctr  out  16  completed TS count since reset/en_n; wraps at 16'hFFFF -> 0

Behaviour:
- Reset (reset_n low, async) or en_n high (sync):
  - State goes to IDLE.
  - txdata = 8'h00, txdatak = 0, busy = 0, set_done = 0, tsctr = 0.
  - Remaining-count, stop_pend and SKP counter are cleared.
  - Reset or en_n mid-set truncates the set immediately; no completion is counted.
- States: IDLE, TS, SKP (SKP only with the SKP feature).
- IDLE:
  - Outputs 8'h00 with k = 0.
  - If start is high, latch num_sets into rem and go to TS with idx = 0.
  - stop is ignored in IDLE; start and stop together in IDLE count as start.
- Latency and timing:
  - start high in cycle N gives COM on txdata in cycle N+1.
  - One symbol per cycle, no gaps between sets.
- TS symbol map (idx 0..15):
  - idx 0: COM 8'hBC, k = 1.
  - idx 1: PAD 8'hF7 with k = 1 if pad_link, else link_num with k = 0.
  - idx 2: PAD 8'hF7 with k = 1 if pad_lane, else lane_num with k = 0.
  - idx 3: nfts, k = 0.
  - idx 4: rate_id, k = 0.
  - idx 5: train_ctrl, k = 0.
  - idx 6..15: TS ID, k = 0.
- Field snapshot: all field inputs, including ts_type and pad flags, are snapshotted in the cycle the set is started (the cycle before its COM). Changes mid-set take effect from the next set.
- At idx 15:
  - set_done = 1 and tsctr increments.
  - If rem != 0, rem decrements.
  - The burst ends when the latched count reaches 0 after decrement, or when stop_pend is set or stop is high this cycle. On end, go to IDLE.
  - Otherwise idx returns to 0 for the next set.
- stop while busy: sets sticky stop_pend; the current set always completes. start while busy: ignored.
- busy is high in every cycle a TS or SKP symbol is on txdata.

Optional Feature:
- Macro: TSGEN_SKP_INSERT_EN.
- Defined:
  - A SKP counter counts completed sets within the burst (cleared on start).
  - When it reaches SKP_INTERVAL and the burst is not ending, emit one SKP ordered set before the next TS: COM 8'hBC, then 8'h1C x3, all k = 1. Then clear the counter.
  - SKP is not counted in tsctr and does not pulse set_done.
  - No SKP follows the final set. stop during SKP lets the SKP finish, then go to IDLE.
- Undefined: the SKP state and counter are absent, SKP_INTERVAL is unused, and there is never a SKP insertion.

Decomposition:
- Shared package in ozdefs.sv: COM, PAD, SKP, TS1ID, TS2ID symbol constants; ts_type_e enum (TS1, TS2); ts_gen_state_e enum (IDLE, TS, SKP).
- One sub-module: ts_symbol_mux, a combinational map from idx plus snapshotted fields to {txdatak, txdata}; the FSM registers its output.

Test Plan:
- start, num_sets = 2, TS1, pad_link = pad_lane = 1, nfts = 8'h20 -> 32 symbols: BC/k, F7/k, F7/k, 20, rate, ctrl, 4A x10, twice. set_done pulses at offsets 16 and 32; tsctr = 2; then idle 00 with busy = 0.
- TS2, link = 8'h01, lane = 8'h03, num_sets = 1 -> symbols 1..2 are 01/03 with k = 0, symbols 6..15 are 45.
- num_sets = 0 continuous, stop asserted at idx 7 of set 3 -> set 3 completes, tsctr = 3, next cycle idle.
- en_n asserted at idx 9 of set 1 -> next cycle txdata = 00, busy = 0, tsctr = 0. start while busy is ignored.
- With TSGEN_SKP_INSERT_EN, SKP_INTERVAL = 2, num_sets = 5 -> sequence TS, TS, SKP, TS, TS, SKP, TS (BC,1C,1C,1C all k = 1); tsctr = 5; no trailing SKP.
- nfts changed from 8'h20 to 8'h40 mid-set 1 of a 2-set burst -> set 1 carries 20, set 2 carries 40.

Source files
------------

// File: rtl/ozdefs.sv
// rtl/ozdefs.sv - shared symbol constants and types for the training-set generator
//
// Purpose: symbol codes (COM, PAD, SKP, TS IDs), ordered-set type and FSM
// state enums, and the snapshotted per-set field bundle.
// Ports: none (package).
package ozdefs;

  localparam logic [7:0] COM   = 8'hBC;
  localparam logic [7:0] PAD   = 8'hF7;
  localparam logic [7:0] SKP   = 8'h1C;
  localparam logic [7:0] TS1ID = 8'h4A;
  localparam logic [7:0] TS2ID = 8'h45;

  typedef enum logic {
    TS1 = 1'b0,
    TS2 = 1'b1
  } ts_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TS   = 2'd1,
    ST_SKP  = 2'd2
  } ts_gen_state_e;

  typedef struct packed {
    ts_type_e   ts_type;
    logic       pad_link;
    logic       pad_lane;
    logic [7:0] link_num;
    logic [7:0] lane_num;
    logic [7:0] nfts;
    logic [7:0] rate_id;
    logic [7:0] train_ctrl;
  } ts_fields_t;

  function automatic logic [7:0] ts_id(input ts_type_e t);
    return (t == TS2) ? TS2ID : TS1ID;
  endfunction

endpackage

// File: rtl/ts_symbol_mux.sv
// rtl/ts_symbol_mux.sv - combinational symbol map for TS1/TS2/SKP ordered sets
//
// Purpose: maps generator state, symbol index and snapshotted fields to the
// symbol and K flag that the top registers onto txdata/txdatak.
// Ports:
//   state_i     generator state for the symbol being produced
//   idx_i       symbol index within the ordered set
//   fields_i    field snapshot for the current set
//   sym_data_o  symbol byte
//   sym_k_o     K-symbol flag
module ts_symbol_mux
  import ozdefs::*;
(
  input  ts_gen_state_e state_i,
  input  logic [3:0]    idx_i,
  input  ts_fields_t    fields_i,
  output logic [7:0]    sym_data_o,
  output logic          sym_k_o
);

  always_comb begin
    sym_data_o = 8'h00;
    sym_k_o    = 1'b0;
    case (state_i)
      ST_TS: begin
        case (idx_i)
          4'd0: begin
            sym_data_o = COM;
            sym_k_o    = 1'b1;
          end
          4'd1: begin
            sym_data_o = fields_i.pad_link ? PAD : fields_i.link_num;
            sym_k_o    = fields_i.pad_link;
          end
          4'd2: begin
            sym_data_o = fields_i.pad_lane ? PAD : fields_i.lane_num;
            sym_k_o    = fields_i.pad_lane;
          end
          4'd3:    sym_data_o = fields_i.nfts;
          4'd4:    sym_data_o = fields_i.rate_id;
          4'd5:    sym_data_o = fields_i.train_ctrl;
          default: sym_data_o = ts_id(fields_i.ts_type);
        endcase
      end
      ST_SKP: begin
        sym_data_o = (idx_i == 4'd0) ? COM : SKP;
        sym_k_o    = 1'b1;
      end
      default: begin
        sym_data_o = 8'h00;
        sym_k_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ts_os_gen.sv
// rtl/ts_os_gen.sv - byte-serial TS1/TS2 ordered-set transmitter
//
// Purpose: emits counted or continuous bursts of 16-symbol training sets on a
// txdata/txdatak symbol stream. Optional SKP ordered-set insertion between
// sets is built when TSGEN_SKP_INSERT_EN is defined.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   en_n               synchronous disable; clears like reset
//   start, stop        begin burst (IDLE only) / end after current set
//   num_sets           sets per burst, 0 = continuous
//   ts_type, pad_link, pad_lane, link_num, lane_num, nfts, rate_id, train_ctrl
//                      set fields, snapshotted the cycle before each COM
//   txdata, txdatak    registered symbol stream
//   busy               a TS or SKP symbol is on txdata
//   set_done           pulse coincident with symbol 15 of each TS
//   tsctr              completed TS count, wraps
module ts_os_gen
  import ozdefs::*;
#(
  parameter int unsigned TS_LEN       = 16,
  parameter int unsigned SKP_INTERVAL = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en_n,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  num_sets,
  input  logic        ts_type,
  input  logic        pad_link,
  input  logic        pad_lane,
  input  logic [7:0]  link_num,
  input  logic [7:0]  lane_num,
  input  logic [7:0]  nfts,
  input  logic [7:0]  rate_id,
  input  logic [7:0]  train_ctrl,
  output logic [7:0]  txdata,
  output logic        txdatak,
  output logic        busy,
  output logic        set_done,
  output logic [15:0] tsctr
);

  localparam logic [3:0] LastIdx = 4'(TS_LEN - 1);

  ts_gen_state_e state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    rem_q, rem_d;
  logic          stop_pend_q, stop_pend_d;
  ts_fields_t    fld_q, fld_d;
  ts_fields_t    live_fld;
  logic [15:0]   tsctr_q, tsctr_d;
  logic [7:0]    txdata_q;
  logic          txdatak_q, busy_q, set_done_q;
  logic [7:0]    sym_data;
  logic          sym_k;
`ifdef TSGEN_SKP_INSERT_EN
  localparam logic [3:0] SkpLastIdx = 4'd3;
  logic [7:0]    skp_cnt_q, skp_cnt_d;
`endif

  assign live_fld = '{
    ts_type:    ts_type_e'(ts_type),
    pad_link:   pad_link,
    pad_lane:   pad_lane,
    link_num:   link_num,
    lane_num:   lane_num,
    nfts:       nfts,
    rate_id:    rate_id,
    train_ctrl: train_ctrl
  };

  // Next-state logic describes the symbol that will be on txdata next cycle;
  // the mux output for that position is registered directly.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    stop_pend_d = stop_pend_q;
    fld_d       = fld_q;
    tsctr_d     = tsctr_q;
`ifdef TSGEN_SKP_INSERT_EN
    skp_cnt_d   = skp_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_TS;
          idx_d       = 4'd0;
          rem_d       = num_sets;
          stop_pend_d = 1'b0;
          fld_d       = live_fld;
`ifdef TSGEN_SKP_INSERT_EN
          skp_cnt_d   = 8'd0;
`endif
        end
      end
      ST_TS: begin
        if (stop) stop_pend_d = 1'b1;
        if (idx_q == LastIdx) begin
          if (rem_q != 8'd0) rem_d = rem_q - 8'd1;
          // rem of 0 means continuous, so only a latched count of 1 ends here
          if (rem_q == 8'd1 || stop_pend_q || stop) begin
            state_d     = ST_IDLE;
            idx_d       = 4'd0;
            stop_pend_d = 1'b0;
          end else begin
`ifdef TSGEN_SKP_INSERT_EN
            idx_d = 4'd0;
            if (skp_cnt_q == 8'(SKP_INTERVAL - 1)) begin
              state_d   = ST_SKP;
              skp_cnt_d = 8'd0;
            end else begin
              skp_cnt_d = skp_cnt_q + 8'd1;
              fld_d     = live_fld;
            end
`else
            idx_d = 4'd0;
            fld_d = live_fld;
`endif
          end
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
`ifdef TSGEN_SKP_INSERT_EN
      ST_SKP: begin
        if (stop) stop_pend_d = 1'b1;
        if (idx_q == SkpLastIdx) begin
          idx_d = 4'd0;
          if (stop_pend_q || stop) begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
          end else begin
            state_d = ST_TS;
            fld_d   = live_fld;
          end
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
      end
    endcase
    if (state_d == ST_TS && idx_d == LastIdx) tsctr_d = tsctr_q + 16'd1;
  end

  ts_symbol_mux u_mux (
    .state_i    (state_d),
    .idx_i      (idx_d),
    .fields_i   (fld_d),
    .sym_data_o (sym_data),
    .sym_k_o    (sym_k)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 4'd0;
      rem_q       <= 8'd0;
      stop_pend_q <= 1'b0;
      fld_q       <= '0;
      tsctr_q     <= 16'd0;
      txdata_q    <= 8'h00;
      txdatak_q   <= 1'b0;
      busy_q      <= 1'b0;
      set_done_q  <= 1'b0;
`ifdef TSGEN_SKP_INSERT_EN
      skp_cnt_q   <= 8'd0;
`endif
    end else if (en_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 4'd0;
      rem_q       <= 8'd0;
      stop_pend_q <= 1'b0;
      fld_q       <= '0;
      tsctr_q     <= 16'd0;
      txdata_q    <= 8'h00;
      txdatak_q   <= 1'b0;
      busy_q      <= 1'b0;
      set_done_q  <= 1'b0;
`ifdef TSGEN_SKP_INSERT_EN
      skp_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      stop_pend_q <= stop_pend_d;
      fld_q       <= fld_d;
      tsctr_q     <= tsctr_d;
      txdata_q    <= sym_data;
      txdatak_q   <= sym_k;
      busy_q      <= (state_d != ST_IDLE);
      set_done_q  <= (state_d == ST_TS) && (idx_d == LastIdx);
`ifdef TSGEN_SKP_INSERT_EN
      skp_cnt_q   <= skp_cnt_d;
`endif
    end
  end

  assign txdata   = txdata_q;
  assign txdatak  = txdatak_q;
  assign busy     = busy_q;
  assign set_done = set_done_q;
  assign tsctr    = tsctr_q;

endmodule
